// File: rtl/time_pkg.sv
// -----------------------------------------------------------------------------
// time_pkg
// Shared definitions for the HH:MM multiplexed 7-segment display:
//   - scan_state_e : digit scan order DIG3 (hour tens) .. DIG0 (minute ones)
//   - SEG_*        : active-low segment codes, bit order {g,f,e,d,c,b,a}
//   - AN_*         : active-low anode patterns per digit
//   - MAX_HOUR / MAX_MIN : largest displayable field values
//   - split_tens_ones()  : binary (0..63) to tens/ones without division
// -----------------------------------------------------------------------------
package time_pkg;

  typedef enum logic [1:0] {
    DIG3 = 2'd0,
    DIG2 = 2'd1,
    DIG1 = 2'd2,
    DIG0 = 2'd3
  } scan_state_e;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [3:0] AN_DIG3  = 4'b0111;
  localparam logic [3:0] AN_DIG2  = 4'b1011;
  localparam logic [3:0] AN_DIG1  = 4'b1101;
  localparam logic [3:0] AN_DIG0  = 4'b1110;
  localparam logic [3:0] AN_OFF   = 4'b1111;

  localparam logic [5:0] MAX_HOUR = 6'd23;
  localparam logic [5:0] MAX_MIN  = 6'd59;

  // Returns {tens, ones}. Subtracting 40, 20, 10 in turn is exact for any
  // value below 64: after each step the remainder is below the next weight
  // times two, so every tens bit is decided by a single compare.
  function automatic logic [7:0] split_tens_ones(input logic [5:0] value);
    logic [3:0] tens;
    logic [5:0] rem;
    tens = 4'd0;
    rem  = value;
    if (rem >= 6'd40) begin
      rem  = rem - 6'd40;
      tens = tens + 4'd4;
    end
    if (rem >= 6'd20) begin
      rem  = rem - 6'd20;
      tens = tens + 4'd2;
    end
    if (rem >= 6'd10) begin
      rem  = rem - 6'd10;
      tens = tens + 4'd1;
    end
    return {tens, rem[3:0]};
  endfunction

endpackage

// File: rtl/seg_decode.sv
// -----------------------------------------------------------------------------
// seg_decode
// Maps one decimal digit to its active-low 7-segment code.
// Ports:
//   digit_i [3:0] : digit 0..9 (anything else shows a dash)
//   dash_i        : force the dash pattern regardless of digit_i
//   seg_o   [6:0] : segment code {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module seg_decode
  import time_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       dash_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (!dash_i) begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/time_display.sv
// -----------------------------------------------------------------------------
// time_display
// Scans an HH:MM time onto a 4-digit multiplexed common-anode display.
// Each digit stays lit for DWELL clocks; the hour/minute inputs are sampled
// once per frame (on entry to the hour-tens digit) so a frame never mixes
// old and new values. Out-of-range fields are shown as two dashes.
//
// Parameters:
//   CLK_HZ : clock frequency in Hz (sets the colon blink period)
//   DWELL  : clocks each digit stays lit (>= 2)
// Ports:
//   clock           : system clock, rising edge
//   reset           : asynchronous, active-low
//   hour_count[5:0] : binary hour 0..23
//   min_count [5:0] : binary minute 0..59
//   enable          : display on; low blanks outputs (scan keeps running)
//   seg[6:0]        : segments {g,f,e,d,c,b,a}, active-low, registered
//   an[3:0]         : digit anodes, active-low, registered
//   dp              : colon/decimal point, active-low, registered
//
// Build option: define COLON_BLINK_EN to blink the colon at 1 Hz (lit during
// the first half of each second); otherwise the colon is lit steadily.
// -----------------------------------------------------------------------------
module time_display
  import time_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned DWELL  = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] hour_count,
  input  logic [5:0] min_count,
  input  logic       enable,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int unsigned   DW         = $clog2(DWELL);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  if (DWELL < 2) begin : g_dwell_chk
    $error("time_display: DWELL must be at least 2");
  end
  if (CLK_HZ < 2) begin : g_clk_chk
    $error("time_display: CLK_HZ must be at least 2");
  end

  // ---------------------------------------------------------------------------
  // Dwell counter and scan FSM
  // ---------------------------------------------------------------------------
  scan_state_e   state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          dwell_last;
  logic          frame_start;

  assign dwell_last  = (dwell_q == DWELL_LAST);
  // The edge that moves DIG0 -> DIG3 is also the shadow capture edge.
  assign frame_start = dwell_last && (state_q == DIG0);

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q + DW'(1);
    if (dwell_last) begin
      dwell_d = '0;
      case (state_q)
        DIG3:    state_d = DIG2;
        DIG2:    state_d = DIG1;
        DIG1:    state_d = DIG0;
        default: state_d = DIG3;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= DIG3;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-frame shadow of the time inputs
  // ---------------------------------------------------------------------------
  logic [5:0] hour_q, min_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hour_q <= '0;
      min_q  <= '0;
    end else if (frame_start) begin
      hour_q <= hour_count;
      min_q  <= min_count;
    end
  end

  logic [3:0] hour_tens, hour_ones, min_tens, min_ones;
  logic       hour_bad, min_bad;

  assign {hour_tens, hour_ones} = split_tens_ones(hour_q);
  assign {min_tens,  min_ones}  = split_tens_ones(min_q);
  assign hour_bad = (hour_q > MAX_HOUR);
  assign min_bad  = (min_q  > MAX_MIN);

  // ---------------------------------------------------------------------------
  // Colon enable
  // ---------------------------------------------------------------------------
  logic colon_on;

`ifdef COLON_BLINK_EN
  localparam int unsigned   BW         = $clog2(CLK_HZ);
  localparam logic [BW-1:0] BLINK_LAST = BW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLINK_HALF = BW'(CLK_HZ >> 1);

  logic [BW-1:0] blink_q, blink_d;

  assign blink_d  = (blink_q == BLINK_LAST) ? '0 : blink_q + BW'(1);
  assign colon_on = (blink_q < BLINK_HALF);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_q <= '0;
    end else begin
      blink_q <= blink_d;
    end
  end
`else
  assign colon_on = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Digit mux and the single shared decoder
  // ---------------------------------------------------------------------------
  logic [3:0] digit_sel;
  logic       dash_sel;
  logic [3:0] an_sel;
  logic       dp_sel;
  logic [6:0] seg_code;

  always_comb begin
    digit_sel = hour_tens;
    dash_sel  = hour_bad;
    an_sel    = AN_DIG3;
    dp_sel    = 1'b1;
    case (state_q)
      DIG3: begin
        digit_sel = hour_tens;
        dash_sel  = hour_bad;
        an_sel    = AN_DIG3;
      end
      DIG2: begin
        digit_sel = hour_ones;
        dash_sel  = hour_bad;
        an_sel    = AN_DIG2;
        dp_sel    = ~colon_on;
      end
      DIG1: begin
        digit_sel = min_tens;
        dash_sel  = min_bad;
        an_sel    = AN_DIG1;
      end
      default: begin
        digit_sel = min_ones;
        dash_sel  = min_bad;
        an_sel    = AN_DIG0;
      end
    endcase
  end

  seg_decode u_seg_decode (
    .digit_i (digit_sel),
    .dash_i  (dash_sel),
    .seg_o   (seg_code)
  );

  // ---------------------------------------------------------------------------
  // Registered outputs (all three move on the same edge)
  // ---------------------------------------------------------------------------
  logic [6:0] seg_q, seg_d;
  logic [3:0] an_q,  an_d;
  logic       dp_q,  dp_d;

  always_comb begin
    seg_d = SEG_OFF;
    an_d  = AN_OFF;
    dp_d  = 1'b1;
    if (enable) begin
      seg_d = seg_code;
      an_d  = an_sel;
      dp_d  = dp_sel;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
      dp_q  <= 1'b1;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
      dp_q  <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_time_display.sv
// -----------------------------------------------------------------------------
// tb_time_display
// Self-checking bench for time_display with CLK_HZ=16, DWELL=4.
// A timeline model predicts seg/an/dp from the number of clock edges since
// reset release; a compare process checks every cycle, and directed frames
// pin the model with hand-computed codes.
// -----------------------------------------------------------------------------
module tb_time_display;

  localparam int CLK_HZ = 16;
  localparam int DWELL  = 4;
  localparam int FRAME  = 4 * DWELL;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] hour_count = 6'd0;
  logic [5:0] min_count  = 6'd0;
  logic       enable     = 1'b1;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int tests_run    = 0;
  int tests_failed = 0;

  time_display #(
    .CLK_HZ (CLK_HZ),
    .DWELL  (DWELL)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .hour_count (hour_count),
    .min_count  (min_count),
    .enable     (enable),
    .seg        (seg),
    .an         (an),
    .dp         (dp)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] digit_code(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Timeline model: after edge t the outputs show digit ((t-1)/DWELL)%4 of the
  // time sampled at the most recent positive multiple of FRAME before t.
  // ---------------------------------------------------------------------------
  int         edges   = 0;
  int         sh_hour = 0;
  int         sh_min  = 0;
  logic [6:0] exp_seg = 7'h7F;
  logic [3:0] exp_an  = 4'hF;
  logic       exp_dp  = 1'b1;

  initial begin
    int pos;
    int val;
    bit bad;
    bit blink_ok;
    forever begin
      @(posedge clock);
      if (!reset) begin
        edges   = 0;
        sh_hour = 0;
        sh_min  = 0;
        exp_seg = 7'h7F;
        exp_an  = 4'hF;
        exp_dp  = 1'b1;
      end else begin
        edges++;
        pos = ((edges - 1) / DWELL) % 4;
`ifdef COLON_BLINK_EN
        blink_ok = (((edges - 1) % CLK_HZ) < (CLK_HZ / 2));
`else
        blink_ok = 1'b1;
`endif
        if (!enable) begin
          exp_seg = 7'h7F;
          exp_an  = 4'hF;
          exp_dp  = 1'b1;
        end else begin
          case (pos)
            0:       begin bad = (sh_hour > 23); val = sh_hour / 10; exp_an = 4'b0111; end
            1:       begin bad = (sh_hour > 23); val = sh_hour % 10; exp_an = 4'b1011; end
            2:       begin bad = (sh_min > 59);  val = sh_min / 10;  exp_an = 4'b1101; end
            default: begin bad = (sh_min > 59);  val = sh_min % 10;  exp_an = 4'b1110; end
          endcase
          exp_seg = bad ? 7'h3F : digit_code(val);
          exp_dp  = !((pos == 1) && blink_ok);
        end
        if ((edges % FRAME) == 0) begin
          sh_hour = hour_count;
          sh_min  = min_count;
        end
      end
    end
  end

  // Per-cycle compare against the model (sampled on the falling edge).
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        check("rst_seg", seg, 7'h7F);
        check("rst_an",  an,  4'hF);
        check("rst_dp",  dp,  1'b1);
      end else begin
        check("cyc_seg", seg, exp_seg);
        check("cyc_an",  an,  exp_an);
        check("cyc_dp",  dp,  exp_dp);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  task automatic goto_edge(input int e);
    int k;
    k = 0;
    while (edges != e && k < 1000) begin
      @(negedge clock);
      k++;
    end
    if (edges != e) begin
      tests_run++;
      tests_failed++;
      $display("FAIL timeout: at edge %0d, want edge %0d", edges, e);
    end
  endtask

  // Checks the four digits of the frame captured at edge f (multiple of FRAME).
  task automatic check_frame(input string name, input int f,
                             input logic [6:0] s3, input logic [6:0] s2,
                             input logic [6:0] s1, input logic [6:0] s0);
    logic [6:0] s [4];
    logic [3:0] a [4];
    s[0] = s3; s[1] = s2; s[2] = s1; s[3] = s0;
    a[0] = 4'b0111; a[1] = 4'b1011; a[2] = 4'b1101; a[3] = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      goto_edge(f + 2 + DWELL * i);
      check({name, "_seg"}, seg, s[i]);
      check({name, "_an"},  an,  a[i]);
      check({name, "_dp"},  dp,  (i == 1) ? 1'b0 : 1'b1);
      $display("[TB] %s digit %0d: an=%b seg=%h dp=%b", name, i, an, seg, dp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int k;
    #1 reset = 1'b0;
    hour_count = 6'd13;
    min_count  = 6'd45;
    enable     = 1'b1;
    repeat (3) @(negedge clock);
    check("boot_seg", seg, 7'h7F);
    check("boot_an",  an,  4'hF);
    reset = 1'b1;

    // First frame still shows the zeroed shadow; 13:45 appears after capture.
    check_frame("boot0000", 0, 7'h40, 7'h40, 7'h40, 7'h40);
    check_frame("t1345_a", FRAME,     7'h79, 7'h30, 7'h19, 7'h12);
    check_frame("t1345_b", 2 * FRAME, 7'h79, 7'h30, 7'h19, 7'h12);

    hour_count = 6'd0;
    min_count  = 6'd0;
    check_frame("t0000", 3 * FRAME, 7'h40, 7'h40, 7'h40, 7'h40);

    hour_count = 6'd24;
    min_count  = 6'd7;
    check_frame("t2407", 4 * FRAME, 7'h3F, 7'h3F, 7'h40, 7'h78);

    // Minute changes while DIG1 is lit: current frame keeps the old value.
    hour_count = 6'd13;
    min_count  = 6'd45;
    goto_edge(5 * FRAME + 9);
    min_count  = 6'd46;
    goto_edge(5 * FRAME + 14);
    check("midframe_dig0", seg, 7'h12);
    $display("[TB] midframe dig0 seg=%h", seg);
    goto_edge(6 * FRAME + 14);
    check("nextframe_dig0", seg, 7'h02);
    $display("[TB] nextframe dig0 seg=%h", seg);
    goto_edge(7 * FRAME + 14);
    check("nextframe2_dig0", seg, 7'h02);

    // Blank for 6 cycles; scan keeps its phase.
    goto_edge(8 * FRAME + 2);
    enable = 1'b0;
    goto_edge(8 * FRAME + 3);
    check("blank_an",  an,  4'hF);
    check("blank_seg", seg, 7'h7F);
    check("blank_dp",  dp,  1'b1);
    $display("[TB] blanked an=%b seg=%h dp=%b", an, seg, dp);
    goto_edge(8 * FRAME + 8);
    enable = 1'b1;
    goto_edge(8 * FRAME + 9);
    check("reen_an",  an,  4'b1101);
    check("reen_seg", seg, 7'h19);
    $display("[TB] re-enabled an=%b seg=%h", an, seg);

    // Randomised inputs and enable; the compare process does the checking.
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 7) == 0) begin
        hour_count = 6'($urandom_range(0, 31));
        min_count  = 6'($urandom_range(0, 63));
      end
      enable = ($urandom_range(0, 9) != 0);
    end
    enable = 1'b1;

    // Reset in the middle of DIG1: outputs must blank with no clock edge.
    k = 0;
    @(negedge clock);
    while ((edges % FRAME) != 10 && k < 100) begin
      @(negedge clock);
      k++;
    end
    check("pre_rst_an", an, 4'b1101);
    #2 reset = 1'b0;
    #1;
    check("async_rst_seg", seg, 7'h7F);
    check("async_rst_an",  an,  4'hF);
    check("async_rst_dp",  dp,  1'b1);
    $display("[TB] async reset an=%b seg=%h dp=%b", an, seg, dp);
    repeat (2) @(negedge clock);
    hour_count = 6'd9;
    min_count  = 6'd58;
    reset = 1'b1;
    check_frame("post_rst", 0, 7'h40, 7'h40, 7'h40, 7'h40);
    check_frame("t0958", FRAME, 7'h40, 7'h10, 7'h12, 7'h00);
    repeat (8) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
